// File: rtl/chimera_clu_pwr_seq_pkg.sv
// chimera_pkg: shared types and default timing for the cluster power sequencer.
//   clu_pwr_state_e : per-cluster sequencer state (3 bits)
//   clu_pwr_out_t   : Moore output bundle of one cluster
//   pwr_decode      : state -> output bundle
//   cnt_width       : counter width covering all timed intervals
package chimera_pkg;

    localparam int unsigned ChimeraNumClusters   = 5;
    localparam int unsigned ChimeraCluClkCycles  = 4;
    localparam int unsigned ChimeraCluRstCycles  = 8;
    localparam int unsigned ChimeraCluIsoTimeout = 1024;

    typedef enum logic [2:0] {
        CLU_OFF        = 3'd0,
        CLU_CLK_EN     = 3'd1,
        CLU_RST_REL    = 3'd2,
        CLU_DEISO      = 3'd3,
        CLU_ACTIVE     = 3'd4,
        CLU_ISO        = 3'd5,
        CLU_RST_ASSERT = 3'd6,
        CLU_CLK_DIS    = 3'd7
    } clu_pwr_state_e;

    typedef struct packed {
        logic isolate;
        logic clk_en;
        logic rst_n;
        logic active;
        logic busy;
    } clu_pwr_out_t;

    // Output table: (isolate, clk_en, rst_n) plus active/busy flags.
    function automatic clu_pwr_out_t pwr_decode(input clu_pwr_state_e s);
        clu_pwr_out_t o;
        o = '{isolate: 1'b1, clk_en: 1'b0, rst_n: 1'b0, active: 1'b0, busy: 1'b1};
        case (s)
            CLU_OFF:        o = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            CLU_CLK_EN:     o = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
            CLU_RST_REL:    o = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
            CLU_DEISO:      o = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
            CLU_ACTIVE:     o = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
            CLU_ISO:        o = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
            CLU_RST_ASSERT: o = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
            CLU_CLK_DIS:    o = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
            default:        o = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        endcase
        return o;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/chimera_clu_pwr_seq_if.sv
// Control/status bundle between the sequencer, the SoC register file and the
// cluster domain. Signal names keep the sequencer's point of view.
//   slave  : the sequencer (consumes enables/isolated status, drives controls)
//   master : the environment (register file + cluster domain)
interface chimera_clu_pwr_seq_if #(
    parameter int unsigned NumClusters = 5
);
    logic [NumClusters-1:0] cluster_en_i;
    logic [NumClusters-1:0] isolated_i;
    logic [NumClusters-1:0] isolate_o;
    logic [NumClusters-1:0] clu_clk_en_o;
    logic [NumClusters-1:0] clu_rst_no;
    logic [NumClusters-1:0] active_o;
    logic [NumClusters-1:0] busy_o;
    logic [NumClusters-1:0] timeout_o;

    modport slave (
        input  cluster_en_i, isolated_i,
        output isolate_o, clu_clk_en_o, clu_rst_no, active_o, busy_o, timeout_o
    );

    modport master (
        output cluster_en_i, isolated_i,
        input  isolate_o, clu_clk_en_o, clu_rst_no, active_o, busy_o, timeout_o
    );
endinterface

// File: rtl/chimera_clu_pwr_fsm.sv
// One cluster's power/isolation sequencer: FSM plus interval counter.
// Optional macro CHIMERA_CLU_PWR_TIMEOUT_EN bounds the isolation wait.
// Ports: clk_i/rst_i (async active-high), cluster_en_i, isolated_i in;
//        isolate_o, clk_en_o, rst_no, active_o, busy_o, timeout_o out (registered).
module chimera_clu_pwr_fsm
    import chimera_pkg::*;
#(
    parameter int unsigned ClkCycles     = ChimeraCluClkCycles,
    parameter int unsigned RstCycles     = ChimeraCluRstCycles,
    parameter int unsigned TimeoutCycles = ChimeraCluIsoTimeout
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cluster_en_i,
    input  logic isolated_i,
    output logic isolate_o,
    output logic clk_en_o,
    output logic rst_no,
    output logic active_o,
    output logic busy_o,
    output logic timeout_o
);

    localparam int unsigned CntW = cnt_width(ClkCycles, RstCycles, TimeoutCycles);
    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t ClkLast = CntW'(ClkCycles - 1);
    localparam cnt_t RstLast = CntW'(RstCycles - 1);

    clu_pwr_state_e state_q, state_d;
    cnt_t           cnt_q, cnt_d;
    clu_pwr_out_t   out_q, out_d;
    logic           timeout_set;

    // Next state; counter restarts at 0 on every state change.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        timeout_set = 1'b0;
        case (state_q)
            CLU_OFF: if (cluster_en_i) state_d = CLU_CLK_EN;
            CLU_CLK_EN: begin
                if (cnt_q == ClkLast) state_d = CLU_RST_REL;
                else                  cnt_d = cnt_q + cnt_t'(1);
            end
            CLU_RST_REL: begin
                if (cnt_q == RstLast) state_d = CLU_DEISO;
                else                  cnt_d = cnt_q + cnt_t'(1);
            end
            // A dropped enable wins over isolation release.
            CLU_DEISO: begin
                if (!cluster_en_i)    state_d = CLU_ISO;
                else if (!isolated_i) state_d = CLU_ACTIVE;
            end
            CLU_ACTIVE: if (!cluster_en_i) state_d = CLU_ISO;
            CLU_ISO: begin
                if (isolated_i) state_d = CLU_RST_ASSERT;
`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
                else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    state_d     = CLU_RST_ASSERT;
                    timeout_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
`endif
            end
            CLU_RST_ASSERT: begin
                if (cnt_q == RstLast) state_d = CLU_CLK_DIS;
                else                  cnt_d = cnt_q + cnt_t'(1);
            end
            CLU_CLK_DIS: begin
                if (cnt_q == ClkLast) state_d = CLU_OFF;
                else                  cnt_d = cnt_q + cnt_t'(1);
            end
            default: state_d = CLU_OFF;
        endcase
        // Outputs decoded from the next state and registered: glitch-free, Moore timing.
        out_d = pwr_decode(state_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= CLU_OFF;
            cnt_q   <= '0;
            out_q   <= pwr_decode(CLU_OFF);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
    logic timeout_q, timeout_d;

    // Sticky flag, cleared when a new power-up starts.
    always_comb begin
        timeout_d = timeout_q;
        if (state_q == CLU_OFF && state_d == CLU_CLK_EN) timeout_d = 1'b0;
        if (timeout_set)                                 timeout_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) timeout_q <= 1'b0;
        else       timeout_q <= timeout_d;
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign isolate_o = out_q.isolate;
    assign clk_en_o  = out_q.clk_en;
    assign rst_no    = out_q.rst_n;
    assign active_o  = out_q.active;
    assign busy_o    = out_q.busy;

endmodule

// File: rtl/chimera_clu_pwr_seq.sv
// Per-cluster power/isolation sequencer array: one independent FSM per cluster.
// Optional macro CHIMERA_CLU_PWR_TIMEOUT_EN enables the isolation-wait timeout.
// Ports: soc_clk_i, rst_i (async active-high);
//        pwr_if.slave: cluster_en_i, isolated_i in;
//        isolate_o, clu_clk_en_o, clu_rst_no, active_o, busy_o, timeout_o out.
module chimera_clu_pwr_seq
    import chimera_pkg::*;
#(
    parameter int unsigned NumClusters   = ChimeraNumClusters,
    parameter int unsigned ClkCycles     = ChimeraCluClkCycles,
    parameter int unsigned RstCycles     = ChimeraCluRstCycles,
    parameter int unsigned TimeoutCycles = ChimeraCluIsoTimeout
) (
    input logic                  soc_clk_i,
    input logic                  rst_i,
    chimera_clu_pwr_seq_if.slave pwr_if
);

    logic [NumClusters-1:0] isolate, clk_en, rst_n, active, busy, timeout;

    for (genvar i = 0; i < NumClusters; i++) begin : g_clu
        chimera_clu_pwr_fsm #(
            .ClkCycles    (ClkCycles),
            .RstCycles    (RstCycles),
            .TimeoutCycles(TimeoutCycles)
        ) u_fsm (
            .clk_i       (soc_clk_i),
            .rst_i       (rst_i),
            .cluster_en_i(pwr_if.cluster_en_i[i]),
            .isolated_i  (pwr_if.isolated_i[i]),
            .isolate_o   (isolate[i]),
            .clk_en_o    (clk_en[i]),
            .rst_no      (rst_n[i]),
            .active_o    (active[i]),
            .busy_o      (busy[i]),
            .timeout_o   (timeout[i])
        );
    end

    assign pwr_if.isolate_o    = isolate;
    assign pwr_if.clu_clk_en_o = clk_en;
    assign pwr_if.clu_rst_no   = rst_n;
    assign pwr_if.active_o     = active;
    assign pwr_if.busy_o       = busy;
    assign pwr_if.timeout_o    = timeout;

endmodule
